// File: rtl/rom_load_pkg.sv
// Shared types for the ROM download controller.
//   ld_state_t : controller state encoding
//   WTBT_FULL  : SDRAM byte enables for a full 16-bit word
//   WTBT_LO    : SDRAM byte enables for the low (even) byte only
package rom_load_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_HOLD,
    S_RUN
  } ld_state_t;

  localparam logic [1:0] WTBT_FULL = 2'b11;
  localparam logic [1:0] WTBT_LO   = 2'b01;
endpackage

// File: rtl/rom_region_decode.sv
// Combinational region decoder for the ROM loader.
// Picks the lowest region k with addr < region_end[k]; region 0 starts at 0,
// region k starts at region_end[k-1].
//   addr       in  : ioctl byte address
//   region_end in  : packed exclusive end per region, region 0 in the LSBs
//   hit        out : one-hot matching region (all zero on miss)
//   offset     out : addr minus the start of the matching region
//   miss       out : addr lies at or beyond the last region end
module rom_region_decode #(
  parameter int ADDR_W = 25,
  parameter int NREG   = 4
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NREG*ADDR_W-1:0] region_end,
  output logic [NREG-1:0]        hit,
  output logic [ADDR_W-1:0]      offset,
  output logic                   miss
);

  logic [ADDR_W-1:0] base;

  always_comb begin
    hit    = '0;
    offset = '0;
    miss   = 1'b1;
    base   = '0;
    for (int k = 0; k < NREG; k++) begin
      // first match wins; base tracks the start of region k
      if (miss && (addr < region_end[k*ADDR_W +: ADDR_W])) begin
        hit[k] = 1'b1;
        offset = addr - base;
        miss   = 1'b0;
      end
      base = region_end[k*ADDR_W +: ADDR_W];
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download controller: packs the data_io byte stream into 16-bit SDRAM
// writes (region 0), steers on-chip regions to one-hot byte strobes, flags
// overflow, and sequences rom_loaded / core_reset.
//   clk_sys, reset                 : clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : data_io download stream
//   region_end                     : packed exclusive region end addresses
//   reset_req                      : OSD / button reset request
//   sdram_we/addr/din/wtbt         : registered SDRAM write port
//   dl_wr/addr/data                : registered on-chip region byte port
//   rom_busy                       : LOAD or FLUSH in progress
//   rom_loaded                     : sticky, first complete load done
//   core_reset                     : reset to the game core
//   overflow                       : sticky, byte past the last region
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int NREG      = 4,
  parameter int ROM_INDEX = 0,
  parameter int HOLD      = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [NREG*ADDR_W-1:0] region_end,
  input  logic                   reset_req,
  output logic                   sdram_we,
  output logic [ADDR_W-1:0]      sdram_addr,
  output logic [15:0]            sdram_din,
  output logic [1:0]             sdram_wtbt,
  output logic [NREG-1:0]        dl_wr,
  output logic [ADDR_W-1:0]      dl_addr,
  output logic [7:0]             dl_data,
  output logic                   rom_busy,
  output logic                   rom_loaded,
  output logic                   core_reset,
  output logic                   overflow
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  ld_state_t state, state_n;
  logic [CNT_W-1:0] cnt;

  // pending even byte of region 0, waiting for its odd partner
  logic              pend, pend_n;
  logic [7:0]        pend_byte, pbyte_n;
  logic [ADDR_W-2:0] pend_addr, paddr_n;

  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       din_n;
  logic [1:0]        wtbt_n;
  logic [NREG-1:0]   dlwr_n;
  logic [ADDR_W-1:0] dladdr_n;
  logic [7:0]        dldata_n;
  logic              ovf_set;

  logic [NREG-1:0]   hit;
  logic [ADDR_W-1:0] offset;
  logic              miss;

  logic rom_dl, accept, same_word, flush_now, start_load;

  rom_region_decode #(.ADDR_W(ADDR_W), .NREG(NREG)) u_dec (
    .addr       (ioctl_addr),
    .region_end (region_end),
    .hit        (hit),
    .offset     (offset),
    .miss       (miss)
  );

  assign rom_dl    = ioctl_download && (ioctl_index == 8'(ROM_INDEX));
  assign accept    = (state == S_LOAD) && ioctl_wr;
  assign same_word = pend && (pend_addr == ioctl_addr[ADDR_W-1:1]);
  // the flush write is issued on the edge into FLUSH so it is visible during
  // FLUSH; FLUSH itself only mops up a byte left by a skip on the last strobe
  assign flush_now = (state == S_LOAD && !ioctl_download) || (state == S_FLUSH);
  assign start_load = (state_n == S_LOAD) && (state != S_LOAD);

  // next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (rom_dl) state_n = S_LOAD;
      S_LOAD:  if (!ioctl_download) state_n = S_FLUSH;
      S_FLUSH: state_n = S_HOLD;
      S_HOLD:  if (cnt == '0 && !reset_req) state_n = S_RUN;
      S_RUN: begin
        if (rom_dl)         state_n = S_LOAD;
        else if (reset_req) state_n = S_HOLD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // write datapath
  always_comb begin
    we_n     = 1'b0;
    addr_n   = sdram_addr;
    din_n    = sdram_din;
    wtbt_n   = sdram_wtbt;
    pend_n   = pend;
    pbyte_n  = pend_byte;
    paddr_n  = pend_addr;
    dlwr_n   = '0;
    dladdr_n = dl_addr;
    dldata_n = dl_data;
    ovf_set  = 1'b0;
    if (accept) begin
      if (hit[0]) begin
        if (!ioctl_addr[0]) begin
          // address skip: the stale even byte goes out alone
          if (pend) begin
            we_n   = 1'b1;
            addr_n = {pend_addr, 1'b0};
            din_n  = {8'h00, pend_byte};
            wtbt_n = WTBT_LO;
          end
          pend_n  = 1'b1;
          pbyte_n = ioctl_dout;
          paddr_n = ioctl_addr[ADDR_W-1:1];
        end else begin
          we_n   = 1'b1;
          addr_n = {ioctl_addr[ADDR_W-1:1], 1'b0};
          din_n  = {ioctl_dout, same_word ? pend_byte : 8'h00};
          wtbt_n = WTBT_FULL;
          pend_n = 1'b0;
        end
      end else if (miss) begin
        ovf_set = 1'b1;
      end else begin
        dlwr_n    = hit;
        dlwr_n[0] = 1'b0;
        dladdr_n  = offset;
        dldata_n  = ioctl_dout;
      end
    end
    // leftover even byte at end of load, only if the port is free this cycle
    if (flush_now && pend_n && !we_n) begin
      we_n   = 1'b1;
      addr_n = {paddr_n, 1'b0};
      din_n  = {8'h00, pbyte_n};
      wtbt_n = WTBT_LO;
      pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      pend_byte  <= '0;
      pend_addr  <= '0;
      sdram_we   <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      sdram_wtbt <= '0;
      dl_wr      <= '0;
      dl_addr    <= '0;
      dl_data    <= '0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      pend_byte  <= pbyte_n;
      pend_addr  <= paddr_n;
      sdram_we   <= we_n;
      sdram_addr <= addr_n;
      sdram_din  <= din_n;
      sdram_wtbt <= wtbt_n;
      dl_wr      <= dlwr_n;
      dl_addr    <= dladdr_n;
      dl_data    <= dldata_n;
      if (state == S_FLUSH) rom_loaded <= 1'b1;
      if (start_load)   overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      // reload on HOLD entry and every cycle reset_req stays high
      if (state_n == S_HOLD && (state != S_HOLD || reset_req)) cnt <= CNT_LOAD;
      else if (state == S_HOLD && cnt != '0)                   cnt <= cnt - 1'b1;
    end
  end

  assign rom_busy = (state == S_LOAD) || (state == S_FLUSH);
  // reset_req is folded in so the core sees reset from the first request cycle
  assign core_reset = !rom_loaded || (state != S_RUN) || reset_req;

endmodule

// File: tb/tb_rom_load_ctrl.sv
module tb_rom_load_ctrl;
  localparam int ADDR_W = 25;
  localparam int NREG   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ioctl_download = 1'b0;
  logic [7:0] ioctl_index = '0;
  logic ioctl_wr = 1'b0;
  logic [ADDR_W-1:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic [NREG*ADDR_W-1:0] region_end;
  logic reset_req = 1'b0;
  logic sdram_we;
  logic [ADDR_W-1:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0] sdram_wtbt;
  logic [NREG-1:0] dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0] dl_data;
  logic rom_busy, rom_loaded, core_reset, overflow;

  assign region_end = {25'h000A000, 25'h0008000};

  always #5 clk = ~clk;

  rom_load_ctrl #(.ADDR_W(ADDR_W), .NREG(NREG), .ROM_INDEX(0), .HOLD(16)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .region_end(region_end), .reset_req(reset_req),
    .sdram_we(sdram_we), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_wtbt(sdram_wtbt), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .rom_busy(rom_busy), .rom_loaded(rom_loaded), .core_reset(core_reset),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
    logic [1:0]        w;
  } sd_t;
  typedef struct packed {
    logic [NREG-1:0]   wr;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } dl_t;

  sd_t sq[$];
  dl_t dq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the oldest pushed expectation
  always @(negedge clk) begin
    if (!reset && sdram_we) begin
      if (sq.size() == 0) chk("sdram_stray", 32'(sq.size()), 32'd1);
      else begin
        sd_t e;
        e = sq.pop_front();
        chk("sdram_addr", 32'(sdram_addr), 32'(e.a));
        chk("sdram_din",  32'(sdram_din),  32'(e.d));
        chk("sdram_wtbt", 32'(sdram_wtbt), 32'(e.w));
      end
    end
    if (!reset && dl_wr != '0) begin
      if (dq.size() == 0) chk("dl_stray", 32'(dq.size()), 32'd1);
      else begin
        dl_t e;
        e = dq.pop_front();
        chk("dl_wr",   32'(dl_wr),   32'(e.wr));
        chk("dl_addr", 32'(dl_addr), 32'(e.a));
        chk("dl_data", 32'(dl_data), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick(); tick();
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick(); tick();
  endtask

  task automatic push_sd(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] w);
    sd_t e;
    e.a = a; e.d = d; e.w = w;
    sq.push_back(e);
  endtask

  task automatic push_dl(input logic [NREG-1:0] wr, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    dl_t e;
    e.wr = wr; e.a = a; e.d = d;
    dq.push_back(e);
  endtask

  // count core_reset-high negedges until it drops, bounded
  task automatic wait_run(input string tag, input int exp_n);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!core_reset) begin done = 1'b1; break; end
      n++;
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    chk({tag, "_len"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(sdram_we), 32'd0);
    chk("rst_dlwr", 32'(dl_wr), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_din", 32'(sdram_din), 32'd0);
    chk("rst_wtbt", 32'(sdram_wtbt), 32'd0);
    chk("rst_loaded", 32'(rom_loaded), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_busy", 32'(rom_busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // non-ROM index is ignored
    start_dl(8'd1);
    wr_byte(25'h0, 8'h99);
    chk("idx_busy", 32'(rom_busy), 32'd0);
    chk("idx_core_reset", 32'(core_reset), 32'd1);
    ioctl_download = 1'b0;
    tick(); tick();

    // abort mid-stream: pending byte discarded, no flush write
    start_dl(8'd0);
    chk("abort_busy_pre", 32'(rom_busy), 32'd1);
    wr_byte(25'h0, 8'h77);
    reset = 1'b1; ioctl_download = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy", 32'(rom_busy), 32'd0);
    chk("abort_loaded", 32'(rom_loaded), 32'd0);

    // odd-length download with flush
    start_dl(8'd0);
    wr_byte(25'h0, 8'hAA);
    push_sd(25'h0, 16'hBBAA, 2'b11);
    wr_byte(25'h1, 8'hBB);
    wr_byte(25'h2, 8'hCC);
    push_sd(25'h2, 16'h00CC, 2'b01);
    ioctl_download = 1'b0;
    tick();
    @(negedge clk);
    chk("flush_busy", 32'(rom_busy), 32'd1);
    chk("flush_we", 32'(sdram_we), 32'd1);
    chk("flush_loaded_pre", 32'(rom_loaded), 32'd0);
    @(negedge clk);
    chk("hold_loaded", 32'(rom_loaded), 32'd1);
    chk("hold_busy", 32'(rom_busy), 32'd0);
    wait_run("holdA", 15);

    // pairing, on-chip region, overflow
    start_dl(8'd0);
    wr_byte(25'h0, 8'h11);
    push_sd(25'h0, 16'h2211, 2'b11);
    wr_byte(25'h1, 8'h22);
    push_dl(2'b10, 25'h3, 8'h5A);
    wr_byte(25'h8003, 8'h5A);
    wr_byte(25'hA000, 8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    ioctl_download = 1'b0;
    tick();
    @(negedge clk);
    chk("flushB_busy", 32'(rom_busy), 32'd1);
    chk("flushB_nowe", 32'(sdram_we), 32'd0);
    wait_run("holdB", 16);

    // reset request hold: 3 request cycles + 16 hold cycles
    reset_req = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!core_reset) break;
      n++;
      if (i == 2) begin @(posedge clk); #1 reset_req = 1'b0; end
    end
    chk("reset_hold_len", 32'(n), 32'd19);

    // overflow clears on new load; skip and odd-first cases
    start_dl(8'd0);
    @(negedge clk);
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("reload_loaded", 32'(rom_loaded), 32'd1);
    chk("reload_busy", 32'(rom_busy), 32'd1);
    wr_byte(25'h10, 8'h31);
    push_sd(25'h10, 16'h0031, 2'b01);
    wr_byte(25'h14, 8'h32);
    push_sd(25'h14, 16'h3332, 2'b11);
    wr_byte(25'h15, 8'h33);
    push_sd(25'h20, 16'h4400, 2'b11);
    wr_byte(25'h21, 8'h44);
    ioctl_download = 1'b0;
    tick();
    wait_run("holdC", 17);

    tick(); tick();
    chk("sdram_q_empty", 32'(sq.size()), 32'd0);
    chk("dl_q_empty", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
